// File: rtl/pendigits_tnn.sv
// Pipelined ternary neural network classifier for pen-digit features.
// Two stages: the hidden layer is evaluated from inp and captured in mid_q, then
// the class scores and argmax are evaluated from mid_q and captured in klass.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   inp    - N unsigned B-bit features, feature i at inp[B*i +: B]
//   klass  - registered predicted class index
module pendigits_tnn #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 40,
  parameter int unsigned B = 4,
  parameter int unsigned C = 10,
  parameter logic [2*N*M-1:0] W1 = '0,
  parameter logic [2*M*C-1:0] W2 = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*B-1:0]       inp,
  output logic [$clog2(C)-1:0] klass
);

  // Hidden sum spans -N*(2^B-1)..+N*(2^B-1); one extra bit carries the sign.
  localparam int unsigned SW = $clog2(N * ((2 ** B) - 1) + 1) + 1;
  localparam int unsigned SL = $clog2(M + 1);
  localparam int unsigned KW = $clog2(C);

  logic [M-1:0]  h_c;
  logic [M-1:0]  mid_d, mid_q;
  logic          vld_d, vld_q;
  logic [KW-1:0] amax_c;
  logic [KW-1:0] klass_d, klass_q;

  // Layer 1: ternary dot product per hidden neuron, thresholded at s >= 0.
  always_comb begin : l1_comb
    logic signed [SW-1:0] acc;
    acc = '0;
    h_c = '0;
    for (int k = 0; k < M; k++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        if (W1[2*(k*N+i) +: 2] == 2'b01) begin
          acc = acc + SW'(inp[B*i +: B]);
        end else if (W1[2*(k*N+i) +: 2] == 2'b11) begin
          acc = acc - SW'(inp[B*i +: B]);
        end
      end
      h_c[k] = ~acc[SW-1];
    end
  end

  // Layer 2 and argmax: count agreeing hidden bits per class; strict '>' keeps
  // the lowest index on ties.
  always_comb begin : l2_comb
    logic [SL-1:0] cnt;
    logic [SL-1:0] best_cnt;
    logic [KW-1:0] best_idx;
    cnt      = '0;
    best_cnt = '0;
    best_idx = '0;
    for (int j = 0; j < C; j++) begin
      cnt = '0;
      for (int k = 0; k < M; k++) begin
        if ((W2[2*(j*M+k) +: 2] == 2'b01 &&  mid_q[k]) ||
            (W2[2*(j*M+k) +: 2] == 2'b11 && !mid_q[k])) begin
          cnt = cnt + SL'(1);
        end
      end
      if (cnt > best_cnt) begin
        best_cnt = cnt;
        best_idx = KW'(j);
      end
    end
    amax_c = best_idx;
  end

  // The first edge after reset only loads mid; klass stays cleared until mid
  // holds data derived from a real input.
  always_comb begin : nxt_comb
    mid_d   = h_c;
    vld_d   = 1'b1;
    klass_d = vld_q ? amax_c : '0;
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_q   <= '0;
      vld_q   <= 1'b0;
      klass_q <= '0;
    end else begin
      mid_q   <= mid_d;
      vld_q   <= vld_d;
      klass_q <= klass_d;
    end
  end

  assign klass = klass_q;

endmodule

// File: tb/tb_pendigits_tnn.sv
// Self-checking bench for pendigits_tnn: several weight sets side by side, a
// random/directed input stream, and a behavioural reference classifier.
module tb_pendigits_tnn;

  localparam int unsigned NN = 16;
  localparam int unsigned MM = 40;
  localparam int unsigned BB = 4;
  localparam int unsigned CC = 10;
  localparam int unsigned KW = $clog2(CC);
  localparam int unsigned L1 = 2 * NN * MM;
  localparam int unsigned L2 = 2 * MM * CC;

  // Random ternary codes (all four encodings) from a xorshift sequence.
  function automatic logic [L1-1:0] gen_w1(input logic [31:0] seed);
    logic [31:0]   s;
    logic [L1-1:0] w;
    s = seed;
    w = '0;
    for (int i = 0; i < NN * MM; i++) begin
      s = s ^ (s << 13);
      s = s ^ (s >> 17);
      s = s ^ (s << 5);
      w[2*i +: 2] = s[1:0];
    end
    return w;
  endfunction

  function automatic logic [L2-1:0] gen_w2(input logic [31:0] seed);
    logic [31:0]   s;
    logic [L2-1:0] w;
    s = seed;
    w = '0;
    for (int i = 0; i < MM * CC; i++) begin
      s = s ^ (s << 13);
      s = s ^ (s >> 17);
      s = s ^ (s << 5);
      w[2*i +: 2] = s[1:0];
    end
    return w;
  endfunction

  // Rows r0 and r1 (r1 < 0: none) set to all +1, everything else zero.
  function automatic logic [L2-1:0] rows_plus(input int r0, input int r1);
    logic [L2-1:0] w;
    w = '0;
    for (int k = 0; k < MM; k++) begin
      w[2*(r0*MM+k) +: 2] = 2'b01;
      if (r1 >= 0) w[2*(r1*MM+k) +: 2] = 2'b01;
    end
    return w;
  endfunction

  function automatic logic [L1-1:0] sgn_w1();
    logic [L1-1:0] w;
    w = '0;
    w[1:0] = 2'b11;
    return w;
  endfunction

  function automatic logic [L2-1:0] sgn_w2();
    logic [L2-1:0] w;
    w = '0;
    w[2*(9*MM) +: 2] = 2'b11;
    return w;
  endfunction

  localparam logic [L1-1:0] ZW1   = '0;
  localparam logic [L2-1:0] ZW2   = '0;
  localparam logic [L2-1:0] C3W2  = rows_plus(3, -1);
  localparam logic [L2-1:0] TIEW2 = rows_plus(2, 7);
  localparam logic [L1-1:0] SGW1  = sgn_w1();
  localparam logic [L2-1:0] SGW2  = sgn_w2();
  localparam logic [L1-1:0] RW1   = gen_w1(32'h1234_5678);
  localparam logic [L2-1:0] RW2   = gen_w2(32'h9e37_79b9);

  logic              clk;
  logic              rst_n;
  logic [NN*BB-1:0]  inp;
  logic [KW-1:0]     k_def, k_c3, k_tie, k_sgn, k_rnd;

  pendigits_tnn #(.N(NN), .M(MM), .B(BB), .C(CC))
    u_def (.clk(clk), .rst_n(rst_n), .inp(inp), .klass(k_def));
  pendigits_tnn #(.N(NN), .M(MM), .B(BB), .C(CC), .W1(ZW1), .W2(C3W2))
    u_c3  (.clk(clk), .rst_n(rst_n), .inp(inp), .klass(k_c3));
  pendigits_tnn #(.N(NN), .M(MM), .B(BB), .C(CC), .W1(ZW1), .W2(TIEW2))
    u_tie (.clk(clk), .rst_n(rst_n), .inp(inp), .klass(k_tie));
  pendigits_tnn #(.N(NN), .M(MM), .B(BB), .C(CC), .W1(SGW1), .W2(SGW2))
    u_sgn (.clk(clk), .rst_n(rst_n), .inp(inp), .klass(k_sgn));
  pendigits_tnn #(.N(NN), .M(MM), .B(BB), .C(CC), .W1(RW1), .W2(RW2))
    u_rnd (.clk(clk), .rst_n(rst_n), .inp(inp), .klass(k_rnd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int edges  = 0;
  logic [NN*BB-1:0] hist1, hist2;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wval(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  // Reference classifier: integer dot products, vote counts, then the first
  // class that reaches the maximum score.
  function automatic int ref_class(input logic [L1-1:0] w1, input logic [L2-1:0] w2,
                                   input logic [NN*BB-1:0] x);
    bit h[MM];
    int score[CC];
    int s, w, mx;
    for (int k = 0; k < MM; k++) begin
      s = 0;
      for (int i = 0; i < NN; i++) s += wval(w1[2*(k*NN+i) +: 2]) * int'(x[BB*i +: BB]);
      h[k] = (s >= 0);
    end
    for (int j = 0; j < CC; j++) begin
      score[j] = 0;
      for (int k = 0; k < MM; k++) begin
        w = wval(w2[2*(j*MM+k) +: 2]);
        if ((w == 1 && h[k]) || (w == -1 && !h[k])) score[j]++;
      end
    end
    mx = 0;
    for (int j = 0; j < CC; j++) if (score[j] > mx) mx = score[j];
    for (int j = 0; j < CC; j++) if (score[j] == mx) return j;
    return 0;
  endfunction

  task automatic check_all(input string tag);
    bit ok;
    ok = (edges >= 2);
    chk_eq({tag, "/def"}, int'(k_def), ok ? ref_class(ZW1,  ZW2,   hist2) : 0);
    chk_eq({tag, "/c3"},  int'(k_c3),  ok ? ref_class(ZW1,  C3W2,  hist2) : 0);
    chk_eq({tag, "/tie"}, int'(k_tie), ok ? ref_class(ZW1,  TIEW2, hist2) : 0);
    chk_eq({tag, "/sgn"}, int'(k_sgn), ok ? ref_class(SGW1, SGW2,  hist2) : 0);
    chk_eq({tag, "/rnd"}, int'(k_rnd), ok ? ref_class(RW1,  RW2,   hist2) : 0);
    if (ok) begin
      chk_eq({tag, "/c3k"},  int'(k_c3),  3);
      chk_eq({tag, "/tiek"}, int'(k_tie), 2);
      chk_eq({tag, "/sgnk"}, int'(k_sgn), (hist2[BB-1:0] != '0) ? 9 : 0);
    end
  endtask

  // One clock edge: track what the pipeline should hold, then sample #1 later.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      edges = 0;
    end else begin
      hist2 = hist1;
      hist1 = inp;
      edges++;
    end
    #1;
    check_all(tag);
  endtask

  function automatic logic [NN*BB-1:0] rnd_inp();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [NN*BB-1:0] with_f0(input logic [BB-1:0] f0);
    logic [NN*BB-1:0] v;
    v = rnd_inp();
    v[BB-1:0] = f0;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    inp   = rnd_inp();
    hist1 = '0;
    hist2 = '0;
    #2;
    check_all("rst_async");
    repeat (2) step("rst_hold");

    @(negedge clk);
    rst_n = 1'b1;
    inp   = 64'h8f4d96400498fe6f;
    repeat (3) step("fixed");

    repeat (150) begin
      inp = rnd_inp();
      step("rand");
    end

    for (int f = 0; f < 16; f++) begin
      inp = with_f0(BB'(f));
      step("f0_sweep");
    end

    for (int n = 0; n < 24; n++) begin
      inp = with_f0((n % 2 == 0) ? 4'd5 : 4'd0);
      step("alt");
    end

    // Reset in the middle of the stream, away from any edge.
    #3;
    rst_n = 1'b0;
    edges = 0;
    #1;
    check_all("rst_mid");
    for (int n = 0; n < 2; n++) begin
      inp = with_f0(4'd5);
      step("rst_mid_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      inp = with_f0((n % 2 == 0) ? 4'd5 : 4'd0);
      step("alt_post");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
